// File: rtl/playbus_pkg.sv
// Shared definitions for PlayBus masters: function codes, St encodings and
// the bus_sequencer state set.
package playbus_pkg;

  localparam logic [2:0] F_ROM2RAM = 3'd4;
  localparam logic [2:0] F_SW2RAM  = 3'd3;
  localparam logic [2:0] F_ROM2LED = 3'd6;
  localparam logic [2:0] F_RAM2LED = 3'd7;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START_SRC = 2'd1;
  localparam logic [1:0] ST_DO_WRITE  = 2'd2;
  localparam logic [1:0] ST_END       = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RELEASE,
    S_DWELL,
    S_ABORT
  } seq_state_e;

  // MODE selector to PlayBus function code.
  function automatic logic [2:0] mode_to_func(input logic [1:0] mode);
    logic [2:0] f;
    case (mode)
      2'd0:    f = F_ROM2RAM;
      2'd1:    f = F_SW2RAM;
      2'd2:    f = F_ROM2LED;
      default: f = F_RAM2LED;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/start_sync.sv
// START push-button synchroniser: two metastability flops, then a registered
// rising-edge detector giving a one-cycle start_pulse three edges after START.
module start_sync (
  input  logic CK2HZ,
  input  logic CLR,
  input  logic START,
  output logic start_pulse
);

  logic meta_q;
  logic sync_q;
  logic sync_prev_q;
  logic pulse_q;

  // Synchronise START and register its rising edge.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      meta_q      <= START;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
      pulse_q     <= sync_q & ~sync_prev_q;
    end
  end

  assign start_pulse = pulse_q;

endmodule

// File: rtl/bus_sequencer.sv
// PlayBus command sequencer: turns one START press into COUNT+1 dynamic
// transfers over consecutive addresses, paced by the controller's St outputs.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start_pulse; DONE/ERR hold the last result
// S_ARM     | GO high, waiting for St==3 under the watchdog
// S_RELEASE | GO low, waiting for the controller to return to St==0
// S_DWELL   | HOLD-cycle gap before the next transfer's GO
// S_ABORT   | run cancelled, GO low, waiting for St==0 before idling
module bus_sequencer
  import playbus_pkg::*;
#(
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic       CK2HZ,
  input  logic       CLR,
  input  logic       START,
  input  logic [1:0] MODE,
  input  logic [3:0] BASE,
  input  logic [3:0] COUNT,
  input  logic [1:0] St,
  output logic [3:0] ADD,
  output logic [2:0] FUNC,
  output logic       GO,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  // Watchdog holds 0..TIMEOUT-1; the edge that would reach TIMEOUT aborts.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Dwell down-counter loaded with HOLD-1; terminal count 0 re-arms GO.
  localparam int DW_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW_W-1:0] DW_LOAD = DW_W'((HOLD > 0) ? HOLD - 1 : 0);

  logic            start_pulse;
  seq_state_e      state_q;
  logic [3:0]      add_q;
  logic [3:0]      rem_q;
  logic [2:0]      func_q;
  logic            go_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [WD_W-1:0] wd_q;
  logic [DW_W-1:0] dwell_q;
  logic [3:0]      add_d;
  logic [3:0]      rem_d;

  start_sync u_start_sync (
    .CK2HZ       (CK2HZ),
    .CLR         (CLR),
    .START       (START),
    .start_pulse (start_pulse)
  );

  // Address and remaining count for the next transfer of the run.
  assign add_d = add_q + 4'd1;
  assign rem_d = rem_q - 4'd1;

  // Sequencer FSM with registered PlayBus outputs and status flags.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      add_q   <= '0;
      rem_q   <= '0;
      func_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      dwell_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pulse) begin
            add_q   <= BASE;
            rem_q   <= COUNT;
            func_q  <= mode_to_func(MODE);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            go_q    <= 1'b1;
            wd_q    <= '0;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          // A late St==3 on the expiry edge still counts as success.
          if (start_pulse) begin
            go_q    <= 1'b0;
            state_q <= S_ABORT;
          end else if (St == ST_END) begin
            go_q    <= 1'b0;
            state_q <= S_RELEASE;
          end else if (wd_q == WD_LAST) begin
            go_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ABORT;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (start_pulse) begin
            state_q <= S_ABORT;
          end else if (St == ST_IDLE) begin
            if (rem_q == '0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (HOLD == 0) begin
              add_q   <= add_d;
              rem_q   <= rem_d;
              go_q    <= 1'b1;
              wd_q    <= '0;
              state_q <= S_ARM;
            end else begin
              dwell_q <= DW_LOAD;
              state_q <= S_DWELL;
            end
          end
        end
        S_DWELL: begin
          if (start_pulse) begin
            state_q <= S_ABORT;
          end else if (dwell_q == '0) begin
            add_q   <= add_d;
            rem_q   <= rem_d;
            go_q    <= 1'b1;
            wd_q    <= '0;
            state_q <= S_ARM;
          end else begin
            dwell_q <= dwell_q - 1'b1;
          end
        end
        S_ABORT: begin
          go_q <= 1'b0;
          if (St == ST_IDLE) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          go_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ADD  = add_q;
  assign FUNC = func_q;
  assign GO   = go_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule
